// File: rtl/mdu_div_seq.sv
// Sequential 32-bit restoring divider for DIV/DIVU.
// Fixed 33-cycle busy window, result registered as {remainder, quotient}.
module mdu_div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  div_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [63:0] result,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] dvs;
   logic        q_neg;
   logic        r_neg;

   logic        op_signed;
   logic        op_start;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] shifted;
   logic        ge;
   logic [31:0] diff;

   assign op_signed = (div_op == 2'b10);
   assign op_start  = (div_op == 2'b10) || (div_op == 2'b01);

   // Magnitude of -2^31 wraps to itself, which yields the defined overflow result.
   assign a_mag = (op_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
   assign b_mag = (op_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;

   assign shifted = {rem, quo[31]};
   assign ge      = (shifted >= {1'b0, dvs});
   assign diff    = shifted[31:0] - dvs;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         done   <= 1'b1;
         result <= 64'd0;
         cnt    <= 5'd0;
         quo    <= 32'd0;
         rem    <= 32'd0;
         dvs    <= 32'd0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (op_start) begin
                  quo   <= a_mag;
                  dvs   <= b_mag;
                  rem   <= 32'd0;
                  q_neg <= op_signed & (dividend[31] ^ divisor[31]);
                  r_neg <= op_signed & dividend[31];
                  cnt   <= 5'd0;
                  done  <= 1'b0;
                  state <= CALC;
               end
            end
            CALC: begin
               rem <= ge ? diff : shifted[31:0];
               quo <= {quo[30:0], ge};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state <= FIX;
               end
            end
            FIX: begin
               result <= {(r_neg ? (32'd0 - rem) : rem),
                          (q_neg ? (32'd0 - quo) : quo)};
               done   <= 1'b1;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b1;
            end
         endcase
      end
   end

endmodule
